hpu_axil_regs: RTL and testbench

- Parametrised AXI4-Lite control/status register block for the HPU. Supersedes the fixed run/matw/last + control pair.
- Makes the n-gram length, words-per-block and item-memory depth software-programmable instead of hard-wired constants.
- Owns the item-memory load address counter, including matw self-clear.
- Adds a sticky done flag (W1C) and byte-strobe writes. Sits between the PS AXI-Lite master and the stream/exe/core control logic.

---
 rtl/hpu_axil_regs.sv | 237 +++++++++++++++++++++++
 tb/tb_hpu_axil_regs.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_axil_regs.sv
// hpu_axil_regs: AXI4-Lite control/status register block for the HPU (n-gram, words, item-memory load).
// Define HPU_AXIL_DECERR_EN to answer unmapped offsets with DECERR; otherwise every response is OKAY.
module hpu_axil_regs #(
  parameter int NGRAM_W    = 20,
  parameter int ITEM_W     = 16,
  parameter int ADDR_LSB_W = 12
) (
  input  logic               S_AXI_ACLK,
  input  logic               S_AXI_ARESETN,
  input  logic [31:0]        S_AXI_AWADDR,
  input  logic               S_AXI_AWVALID,
  output logic               S_AXI_AWREADY,
  input  logic [31:0]        S_AXI_WDATA,
  input  logic [3:0]         S_AXI_WSTRB,
  input  logic               S_AXI_WVALID,
  output logic               S_AXI_WREADY,
  output logic [1:0]         S_AXI_BRESP,
  output logic               S_AXI_BVALID,
  input  logic               S_AXI_BREADY,
  input  logic [31:0]        S_AXI_ARADDR,
  input  logic               S_AXI_ARVALID,
  output logic               S_AXI_ARREADY,
  output logic [31:0]        S_AXI_RDATA,
  output logic [1:0]         S_AXI_RRESP,
  output logic               S_AXI_RVALID,
  input  logic               S_AXI_RREADY,
  input  logic               item_beat,
  input  logic               s_fin,
  output logic               run,
  output logic               matw,
  output logic               last,
  output logic [NGRAM_W-1:0] addr_j,
  output logic [NGRAM_W-1:0] addr_i,
  output logic [ITEM_W-1:0]  item_num,
  output logic [ITEM_W-1:0]  mat_a,
  output logic [31:0]        control
);

  localparam int IDX_W = ADDR_LSB_W - 2;

  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_NGRAM    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_WORDS    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_CONTROL  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_ITEM_NUM = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_MAT_A    = IDX_W'(6);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef HPU_AXIL_DECERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b11;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_WRESP,
    ST_RD1,
    ST_RD2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             done;

  logic             wr_commit;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic [31:0]      wr_mask;
  logic             wr_mapped;
  logic [2:0]       ctrl_new;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_value;
  logic             rd_mapped;
  logic             load_done;
  logic             unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign S_AXI_AWREADY = (state == ST_IDLE) || (state == ST_W);
  assign S_AXI_WREADY  = (state == ST_IDLE) || (state == ST_AW);
  assign S_AXI_ARREADY = (state == ST_IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;

  assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[31:ADDR_LSB_W], S_AXI_AWADDR[1:0],
                              S_AXI_ARADDR[31:ADDR_LSB_W], S_AXI_ARADDR[1:0]};

  // The write commits on the edge that completes the second of the AW/W handshakes,
  // taking whichever half was parked in a holding register.
  always_comb begin
    wr_idx    = (state == ST_AW) ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB_W-1:2];
    wr_data   = (state == ST_W) ? wdata_q : S_AXI_WDATA;
    wr_strb   = (state == ST_W) ? wstrb_q : S_AXI_WSTRB;
    wr_mask   = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    wr_commit = ((state == ST_IDLE) && S_AXI_AWVALID && S_AXI_WVALID) ||
                ((state == ST_AW) && S_AXI_WVALID) ||
                ((state == ST_W) && S_AXI_AWVALID);
    wr_mapped = (wr_idx <= IDX_MAT_A);
    ctrl_new  = ({last, run, matw} & ~wr_mask[2:0]) | (wr_data[2:0] & wr_mask[2:0]);
  end

  assign rd_idx = S_AXI_ARADDR[ADDR_LSB_W-1:2];

  always_comb begin
    rd_value  = 32'd0;
    rd_mapped = 1'b1;
    case (rd_idx)
      IDX_CTRL:     rd_value = {29'd0, last, run, matw};
      IDX_STATUS:   rd_value = {29'd0, done, run, matw};
      IDX_NGRAM:    rd_value = 32'(addr_j);
      IDX_WORDS:    rd_value = 32'(addr_i);
      IDX_CONTROL:  rd_value = control;
      IDX_ITEM_NUM: rd_value = 32'(item_num);
      IDX_MAT_A:    rd_value = 32'(mat_a);
      default:      rd_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state        <= ST_IDLE;
      aw_idx_q     <= '0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= 32'd0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            state        <= ST_WRESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
          end else if (S_AXI_AWVALID) begin
            state    <= ST_AW;
            aw_idx_q <= S_AXI_AWADDR[ADDR_LSB_W-1:2];
          end else if (S_AXI_WVALID) begin
            state   <= ST_W;
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
          end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            state       <= ST_RD1;
            S_AXI_RDATA <= rd_value;
            S_AXI_RRESP <= rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
          end
        end
        ST_AW, ST_W: begin
          if (wr_commit) begin
            state        <= ST_WRESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
          end
        end
        ST_WRESP: begin
          if (S_AXI_BREADY) begin
            state        <= ST_IDLE;
            S_AXI_BVALID <= 1'b0;
          end
        end
        ST_RD1: begin
          state        <= ST_RD2;
          S_AXI_RVALID <= 1'b1;
        end
        ST_RD2: begin
          if (S_AXI_RREADY) begin
            state        <= ST_IDLE;
            S_AXI_RVALID <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign load_done = matw && item_beat && (mat_a == item_num);

  // A bus write to CTRL overrides the load-complete self-clear of matw; s_fin beats the W1C.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      run      <= 1'b0;
      matw     <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      addr_j   <= NGRAM_W'(2);
      addr_i   <= NGRAM_W'(7);
      item_num <= ITEM_W'(99);
      control  <= 32'd0;
      mat_a    <= '0;
    end else begin
      if (wr_commit && (wr_idx == IDX_CTRL)) begin
        matw <= ctrl_new[0];
        run  <= ctrl_new[1];
        last <= ctrl_new[2];
      end else if (load_done) begin
        matw <= 1'b0;
      end

      if (s_fin) begin
        done <= 1'b1;
      end else if (wr_commit && (wr_idx == IDX_STATUS) && wr_mask[2] && wr_data[2]) begin
        done <= 1'b0;
      end

      if (wr_commit && (wr_idx == IDX_NGRAM)) begin
        addr_j <= NGRAM_W'(merge_bytes(32'(addr_j), wr_data, wr_mask));
      end
      if (wr_commit && (wr_idx == IDX_WORDS)) begin
        addr_i <= NGRAM_W'(merge_bytes(32'(addr_i), wr_data, wr_mask));
      end
      if (wr_commit && (wr_idx == IDX_CONTROL)) begin
        control <= merge_bytes(control, wr_data, wr_mask);
      end
      if (wr_commit && (wr_idx == IDX_ITEM_NUM)) begin
        item_num <= ITEM_W'(merge_bytes(32'(item_num), wr_data, wr_mask));
      end

      if (!matw) begin
        mat_a <= '0;
      end else if (item_beat) begin
        mat_a <= (mat_a == item_num) ? '0 : mat_a + ITEM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hpu_axil_regs.sv
// tb_hpu_axil_regs: table vectors, hand-written corner sequences and random traffic
// checked against a transaction-level register model.
module tb_hpu_axil_regs;

  localparam int NGRAM_W = 20;
  localparam int ITEM_W  = 16;
`ifdef HPU_AXIL_DECERR_EN
  localparam logic [1:0] UNMAPPED_RESP = 2'b11;
`else
  localparam logic [1:0] UNMAPPED_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [31:0]        awaddr, wdata, araddr, rdata, control;
  logic [3:0]         wstrb;
  logic               awvalid, awready, wvalid, wready, bvalid, bready;
  logic               arvalid, arready, rvalid, rready;
  logic [1:0]         bresp, rresp;
  logic               item_beat, s_fin, run, matw, last;
  logic [NGRAM_W-1:0] addr_j, addr_i;
  logic [ITEM_W-1:0]  item_num, mat_a;

  hpu_axil_regs #(.NGRAM_W(NGRAM_W), .ITEM_W(ITEM_W), .ADDR_LSB_W(12)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .item_beat(item_beat), .s_fin(s_fin), .run(run), .matw(matw), .last(last),
    .addr_j(addr_j), .addr_i(addr_i), .item_num(item_num), .mat_a(mat_a), .control(control)
  );

  int checks = 0;
  int failures = 0;

  logic        m_matw, m_run, m_last, m_done;
  logic [31:0] m_ngram, m_words, m_control, m_item, m_mata;

  typedef struct {
    logic        doWrite;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expRead;
    logic [1:0]  expResp;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=timeout expected=handshake", name);
  endtask

  task automatic modelReset();
    m_matw = 0; m_run = 0; m_last = 0; m_done = 0;
    m_ngram = 2; m_words = 7; m_control = 0; m_item = 99; m_mata = 0;
  endtask

  function automatic logic [31:0] strbMask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  function automatic logic modelMapped(input logic [31:0] a);
    return (a & 32'h0000_0FFC) <= 32'h18;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    case (a & 32'h0000_0FFC)
      32'h00:  return {29'd0, m_last, m_run, m_matw};
      32'h04:  return {29'd0, m_done, m_run, m_matw};
      32'h08:  return m_ngram;
      32'h0C:  return m_words;
      32'h10:  return m_control;
      32'h14:  return m_item;
      32'h18:  return m_mata;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask, nv;
    mask = strbMask(s);
    nv   = (modelRead(a) & ~mask) | (d & mask);
    case (a & 32'h0000_0FFC)
      32'h00: begin
        m_matw = nv[0]; m_run = nv[1]; m_last = nv[2];
        if (!m_matw) m_mata = 0;
      end
      32'h04: if (mask[2] && d[2]) m_done = 0;
      32'h08: m_ngram   = nv & 32'h000F_FFFF;
      32'h0C: m_words   = nv & 32'h000F_FFFF;
      32'h10: m_control = nv;
      32'h14: m_item    = nv & 32'h0000_FFFF;
      default: ;
    endcase
  endtask

  task automatic checkModelOutputs(input string tag);
    checkOutput({tag, "_matw"}, 32'(matw), 32'(m_matw));
    checkOutput({tag, "_run"}, 32'(run), 32'(m_run));
    checkOutput({tag, "_last"}, 32'(last), 32'(m_last));
    checkOutput({tag, "_addr_j"}, 32'(addr_j), m_ngram);
    checkOutput({tag, "_addr_i"}, 32'(addr_i), m_words);
    checkOutput({tag, "_item_num"}, 32'(item_num), m_item);
    checkOutput({tag, "_control"}, control, m_control);
    checkOutput({tag, "_mat_a"}, 32'(mat_a), m_mata);
  endtask

  task automatic axiWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    logic awGo, wGo, seen;
    int n;
    resp = 2'b01;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      awGo = awvalid & awready;
      wGo  = wvalid & wready;
      @(posedge clk); #1;
      if (awGo) awvalid = 0;
      if (wGo) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) begin
      timeoutFail("write_addr_data");
      awvalid = 0; wvalid = 0;
      return;
    end
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (bvalid) begin seen = 1; resp = bresp; end
    end
    if (!seen) begin timeoutFail("write_bvalid"); return; end
    @(posedge clk); #1;
  endtask

  task automatic axiRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    logic go, seen;
    int n;
    d = 32'hDEAD_BEEF; resp = 2'b01; lat = -1;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (arvalid && n < 20) begin
      @(negedge clk);
      go = arready;
      @(posedge clk); #1;
      if (go) arvalid = 0;
      n++;
    end
    if (arvalid) begin timeoutFail("read_ar"); arvalid = 0; return; end
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rvalid) begin seen = 1; d = rdata; resp = rresp; end
    end
    if (!seen) begin timeoutFail("read_rvalid"); return; end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] d;
    logic [1:0]  r;
    int lat;
    if (v.doWrite) begin
      axiWrite(v.addr, v.data, v.strb, r);
      modelWrite(v.addr, v.data, v.strb);
      checkOutput($sformatf("vec%0d_bresp", idx), 32'(r), 32'(v.expResp));
    end
    axiRead(v.addr, d, r, lat);
    checkOutput($sformatf("vec%0d_rdata", idx), d, v.expRead);
    checkOutput($sformatf("vec%0d_rresp", idx), 32'(r), 32'(v.expResp));
    checkOutput($sformatf("vec%0d_rlatency", idx), 32'(lat), 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d, a, off, cap;
    logic [1:0]  r;
    int lat, n;

    rst_n = 0; awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; item_beat = 0; s_fin = 0;
    modelReset();

    vecs[0]  = '{1'b0, 32'h08,   32'h0,         4'h0, 32'h2,         2'b00};
    vecs[1]  = '{1'b0, 32'h0C,   32'h0,         4'h0, 32'h7,         2'b00};
    vecs[2]  = '{1'b0, 32'h14,   32'h0,         4'h0, 32'd99,        2'b00};
    vecs[3]  = '{1'b0, 32'h00,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[4]  = '{1'b0, 32'h04,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[5]  = '{1'b0, 32'h10,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[6]  = '{1'b0, 32'h18,   32'h0,         4'h0, 32'h0,         2'b00};
    vecs[7]  = '{1'b0, 32'h3C,   32'h0,         4'h0, 32'h0,         UNMAPPED_RESP};
    vecs[8]  = '{1'b1, 32'h10,   32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 2'b00};
    vecs[9]  = '{1'b1, 32'h10,   32'h1234_5678, 4'h5, 32'hFF34_FF78, 2'b00};
    vecs[10] = '{1'b1, 32'h08,   32'hABCD_E123, 4'hF, 32'h000D_E123, 2'b00};
    vecs[11] = '{1'b1, 32'h08,   32'h0000_0005, 4'h1, 32'h000D_E105, 2'b00};
    vecs[12] = '{1'b1, 32'h3C,   32'h1234_5678, 4'hF, 32'h0,         UNMAPPED_RESP};
    vecs[13] = '{1'b1, 32'h04,   32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
    vecs[14] = '{1'b1, 32'h18,   32'h0000_0055, 4'hF, 32'h0,         2'b00};
    vecs[15] = '{1'b1, 32'h100C, 32'h0000_0009, 4'hF, 32'h9,         2'b00};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_awready", 32'(awready), 32'd1);
    checkOutput("reset_wready", 32'(wready), 32'd1);
    checkOutput("reset_arready", 32'(arready), 32'd1);
    checkOutput("reset_bvalid", 32'(bvalid), 32'd0);
    checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_bresp", 32'(bresp), 32'd0);
    checkOutput("reset_rresp", 32'(rresp), 32'd0);
    checkModelOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);
    checkModelOutputs("after_table");

    $display("[TB] AW first, W later, BREADY held low");
    awaddr = 32'h14; awvalid = 1; wvalid = 0; bready = 0;
    @(negedge clk);
    checkOutput("awfirst_arready", 32'(arready), 32'd0);
    @(posedge clk); #1;
    awvalid = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("awheld_wready", 32'(wready), 32'd1);
      checkOutput("awheld_awready", 32'(awready), 32'd0);
      checkOutput("awheld_item_num", 32'(item_num), m_item);
    end
    @(posedge clk); #1;
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0; wdata = 32'h77;
    modelWrite(32'h14, 32'h5, 4'hF);
    checkOutput("awfirst_item_num", 32'(item_num), 32'd5);
    repeat (4) begin
      @(negedge clk);
      checkOutput("bhold_bvalid", 32'(bvalid), 32'd1);
      checkOutput("bhold_item_num", 32'(item_num), 32'd5);
      checkOutput("bhold_wready", 32'(wready), 32'd0);
    end
    @(posedge clk); #1;
    bready = 1;
    @(posedge clk); #1;
    checkOutput("bdone_bvalid", 32'(bvalid), 32'd0);
    axiRead(32'h14, d, r, lat);
    checkOutput("awfirst_readback", d, 32'd5);

    $display("[TB] item-memory load");
    axiWrite(32'h14, 32'd3, 4'hF, r); modelWrite(32'h14, 32'd3, 4'hF);
    axiWrite(32'h00, 32'd1, 4'hF, r); modelWrite(32'h00, 32'd1, 4'hF);
    checkOutput("load_matw_set", 32'(matw), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("load_mat_a_%0d", k), 32'(mat_a), 32'(k));
      if (k == 2) begin
        axiWrite(32'h00, 32'd1, 4'hF, r);
        checkOutput("load_rewrite_keeps_mat_a", 32'(mat_a), 32'd2);
      end
      item_beat = 1;
      @(posedge clk); #1;
      item_beat = 0;
      if (k == 3) begin
        checkOutput("load_done_matw", 32'(matw), 32'd0);
        checkOutput("load_done_mat_a", 32'(mat_a), 32'd0);
      end else begin
        checkOutput($sformatf("load_after_beat_%0d", k), 32'(mat_a), 32'(k + 1));
      end
      repeat (2) @(posedge clk);
      #1;
    end
    m_matw = 0; m_mata = 0;
    axiRead(32'h04, d, r, lat);
    checkOutput("load_status_matw", 32'(d[0]), 32'd0);
    checkOutput("load_status", d, modelRead(32'h04));

    $display("[TB] s_fin against W1C");
    awaddr = 32'h04; wdata = 32'h4; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; s_fin = 1;
    @(posedge clk); #1;
    s_fin = 0; awvalid = 0; wvalid = 0;
    checkOutput("sfin_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    m_done = 1;
    axiRead(32'h04, d, r, lat);
    checkOutput("sfin_done_kept", d, 32'h4);
    axiWrite(32'h04, 32'h4, 4'hF, r); modelWrite(32'h04, 32'h4, 4'hF);
    axiRead(32'h04, d, r, lat);
    checkOutput("w1c_done_cleared", d, 32'h0);

    $display("[TB] reset while RVALID");
    araddr = 32'h08; arvalid = 1; rready = 0;
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 10) begin @(negedge clk); n++; end
    checkOutput("rst_rvalid_before", 32'(rvalid), 32'd1);
    cap = rdata;
    checkOutput("rst_rdata_before", cap, m_ngram);
    @(negedge clk);
    checkOutput("rst_rvalid_stable", 32'(rvalid), 32'd1);
    checkOutput("rst_rdata_stable", rdata, cap);
    rst_n = 0;
    #1;
    checkOutput("rst_rvalid_drop", 32'(rvalid), 32'd0);
    modelReset();
    checkModelOutputs("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    checkOutput("rst_arready_after", 32'(arready), 32'd1);
    rready = 1;
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      off = 32'($urandom_range(0, 9)) * 32'd4;
      a   = ($urandom_range(0, 1) == 1) ? (off | ($urandom & 32'hFFFF_F000)) : off;
      d   = $urandom;
      axiWrite(a, d, 4'($urandom_range(0, 15)), r);
      checkOutput("rand_bresp", 32'(r), modelMapped(a) ? 32'd0 : 32'(UNMAPPED_RESP));
      modelWrite(a, d, wstrb);
      checkModelOutputs("rand");
      axiRead(a, d, r, lat);
      checkOutput("rand_rdata", d, modelRead(a));
      checkOutput("rand_rresp", 32'(r), modelMapped(a) ? 32'd0 : 32'(UNMAPPED_RESP));
      checkOutput("rand_rlatency", 32'(lat), 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
